benes_xbar_pipe: RTL

Pipelined, parametrised Benes permutation crossbar carrying N lanes of DATA-bit words through 2·LOG_N−1 switch columns. It succeeds the fixed two-register hybrid crossbar with a configurable register spacing, per-beat valid/ready flow control with backpressure, and a double-buffered routing table. The table is committed atomically after the pipeline drains. It sits between the request-side lane arbiters and the bank-side lane ports.

---
 rtl/benes_xbar_pipe.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/benes_xbar_pipe.sv
// Pipelined N-lane Benes permutation crossbar with valid/ready flow control and a
// double-buffered routing table. Define BXP_PERF_CNT_EN to add beat/stall counters.
module benes_xbar_pipe #(
  parameter int N          = 8,
  parameter int LOG_N      = 3,
  parameter int DATA       = 16,
  parameter int PIPE_EVERY = 2,
  parameter int STG_W      = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*DATA-1:0]    in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*DATA-1:0]    out_data,
  input  logic                 cfg_we,
  input  logic [STG_W-1:0]     cfg_stage,
  input  logic [N/2-1:0]       cfg_sel,
  input  logic                 cfg_commit,
  output logic                 cfg_busy
`ifdef BXP_PERF_CNT_EN
  ,
  output logic [31:0]          perf_beats,
  output logic [31:0]          perf_stall
`endif
);

  localparam int S = 2*LOG_N - 1;
  localparam int R = (S + PIPE_EVERY - 1) / PIPE_EVERY;
  localparam int W = N*DATA;

  typedef enum logic [1:0] {RUN, DRAIN, SWAP} state_e;

  state_e         state_q, state_d;
  logic [N/2-1:0] act_q [S];
  logic [N/2-1:0] shd_q [S];
  logic [R-1:0]   vld_q;
  logic [W-1:0]   rank_q [R];
  logic [W-1:0]   rank_in [R];
  logic [W-1:0]   col_in [S];
  logic [W-1:0]   col_out [S];
  logic [R-1:0]   load;
  logic [R-1:0]   up_vld;
  logic           accept;

  // Switch columns: each column is fed either by the previous column or, at the
  // start of a register segment, by the preceding rank (or the input port).
  for (genvar s = 0; s < S; s++) begin : g_col
    localparam int D = (s < LOG_N) ? (LOG_N - 1 - s) : (s - LOG_N + 1);
    logic [W-1:0] xo;
    if (s % PIPE_EVERY == 0) begin : g_head
      if (s == 0) begin : g_first
        assign col_in[s] = in_data;
      end else begin : g_rank
        assign col_in[s] = rank_q[s/PIPE_EVERY - 1];
      end
    end else begin : g_chain
      assign col_in[s] = col_out[s-1];
    end
    for (genvar p = 0; p < N; p++) begin : g_sw
      if (((p >> D) & 1) == 0) begin : g_pair
        localparam int Q = p | (1 << D);
        localparam int J = ((p >> (D + 1)) << D) | (p & ((1 << D) - 1));
        assign xo[p*DATA +: DATA] = act_q[s][J] ? col_in[s][Q*DATA +: DATA]
                                                : col_in[s][p*DATA +: DATA];
        assign xo[Q*DATA +: DATA] = act_q[s][J] ? col_in[s][p*DATA +: DATA]
                                                : col_in[s][Q*DATA +: DATA];
      end
    end
    assign col_out[s] = xo;
  end

  for (genvar k = 0; k < R; k++) begin : g_rank_in
    localparam int LAST = ((k + 1)*PIPE_EVERY - 1 < S) ? ((k + 1)*PIPE_EVERY - 1) : (S - 1);
    assign rank_in[k] = col_out[LAST];
  end

  // A rank may load when empty or when its content moves on this same cycle.
  always_comb begin
    logic nxt;
    load = '0;
    nxt  = out_ready;
    for (int k = R - 1; k >= 0; k--) begin
      nxt     = !vld_q[k] || nxt;
      load[k] = nxt;
    end
  end

  assign in_ready = !rst && (state_q == RUN) && load[0];
  assign accept   = in_valid && in_ready;

  always_comb begin
    up_vld    = '0;
    up_vld[0] = accept;
    for (int k = 1; k < R; k++) up_vld[k] = vld_q[k-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int k = 0; k < R; k++) rank_q[k] <= '0;
    end else begin
      for (int k = 0; k < R; k++) begin
        if (load[k]) begin
          vld_q[k] <= up_vld[k];
          if (up_vld[k]) rank_q[k] <= rank_in[k];
        end
      end
    end
  end

  assign out_valid = vld_q[R-1];
  assign out_data  = rank_q[R-1];
  assign cfg_busy  = (state_q != RUN);

  // Commit waits for every rank to empty so no beat ever sees a mixed table.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (cfg_commit) state_d = DRAIN;
      DRAIN:   if (vld_q == '0) state_d = SWAP;
      SWAP:    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      for (int s = 0; s < S; s++) begin
        act_q[s] <= '0;
        shd_q[s] <= '0;
      end
    end else begin
      state_q <= state_d;
      for (int s = 0; s < S; s++) begin
        if (cfg_we && (int'(cfg_stage) == s)) shd_q[s] <= cfg_sel;
        if (state_q == SWAP) act_q[s] <= shd_q[s];
      end
    end
  end

`ifdef BXP_PERF_CNT_EN
  logic [31:0] beats_q, stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beats_q <= '0;
      stall_q <= '0;
    end else begin
      if (out_valid && out_ready && (beats_q != 32'hFFFF_FFFF)) beats_q <= beats_q + 32'd1;
      if (out_valid && !out_ready && (stall_q != 32'hFFFF_FFFF)) stall_q <= stall_q + 32'd1;
    end
  end

  assign perf_beats = beats_q;
  assign perf_stall = stall_q;
`endif

endmodule
